serdesphy_tx_framer: RTL and testbench

TX-path framing/serialization stage between the 4-bit parallel TX user interface and the PMA serializer input.
- Buffers nibbles from tx_data/tx_valid in a small FIFO.
- Emits a sync word when enabled, then data, idle fill or PRBS7.
- Output is an LSB-first serial bit stream, one bit per clock, on tx_serial_data/tx_serial_valid.
- Reports FIFO and error status back to the PCS status/CSR logic.

---
 rtl/serdesphy_tx_framer.sv | 166 ++++++++++++++++
 tb/tb_serdesphy_tx_framer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serdesphy_tx_framer.sv
// TX framer: nibble FIFO feeding a sync-word / data / idle / PRBS7 serializer, LSB-first bit stream.
// Latency: first sync bit one cycle after tx_en; a FIFO nibble reaches the line at the next nibble boundary.
// Backpressure: none toward the user; a write into a full FIFO with no same-cycle pop is dropped and flagged.
module serdesphy_tx_framer #(
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [7:0] SYNC_WORD   = 8'hA5,
  parameter logic [3:0] IDLE_NIBBLE = 4'h5
) (
  input  logic       clk_ref_24m,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       tx_fifo_en,
  input  logic       tx_prbs_en,
  input  logic       tx_idle,
  input  logic       err_clr,
  input  logic [3:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_serial_data,
  output logic       tx_serial_valid,
  output logic       tx_idle_pattern,
  output logic       tx_fifo_full,
  output logic       tx_fifo_empty,
  output logic       tx_overflow,
  output logic       tx_underflow,
  output logic       tx_active
);
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA} state_t;

  state_t        state;
  logic [7:0]    sreg;
  logic [2:0]    cnt;
  logic [6:0]    prbs, prbs_nxt;
  logic [3:0]    prbs_nib, nib;
  logic          nib_idle, last_fifo, load, pop, push, drop, unf_set;
  logic [3:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;

  // Pop only at a nibble load, so a write at full can still land in the slot freed that cycle.
  assign push = tx_fifo_en & tx_valid & (~tx_fifo_full | pop);
  assign drop = tx_fifo_en & tx_valid & tx_fifo_full & ~pop;

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CNT_ONE;
    else if (pop && !push)
      count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk_ref_24m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      tx_fifo_full  <= 1'b0;
      tx_fifo_empty <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count         <= count_nxt;
      tx_fifo_full  <= (count_nxt == FULL_CNT);
      tx_fifo_empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk_ref_24m) begin
    if (push) fifo_mem[wr_ptr] <= tx_data;
  end

  // x^7+x^6+1, four steps per nibble; the first generated bit is sent first.
  always_comb begin
    prbs_nxt = prbs;
    prbs_nib = '0;
    for (int i = 0; i < 4; i++) begin
      prbs_nib[i] = prbs_nxt[6] ^ prbs_nxt[5];
      prbs_nxt    = {prbs_nxt[5:0], prbs_nib[i]};
    end
  end

  assign load = tx_en & (((state == ST_SYNC) & (cnt == 3'd7)) |
                         ((state == ST_DATA) & (cnt == 3'd3)));

  always_comb begin
    nib      = IDLE_NIBBLE;
    nib_idle = 1'b1;
    pop      = 1'b0;
    unf_set  = 1'b0;
    if (tx_prbs_en) begin
      nib      = prbs_nib;
      nib_idle = 1'b0;
    end else if (!tx_idle && !tx_fifo_empty) begin
      nib      = fifo_mem[rd_ptr];
      nib_idle = 1'b0;
      pop      = load;
    end else if (!tx_idle) begin
      unf_set  = load & last_fifo;
    end
  end

  assign tx_serial_data = sreg[0];

  always_ff @(posedge clk_ref_24m or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      sreg            <= '0;
      cnt             <= '0;
      prbs            <= 7'h7F;
      last_fifo       <= 1'b0;
      tx_serial_valid <= 1'b0;
      tx_idle_pattern <= 1'b0;
      tx_active       <= 1'b0;
    end else if (!tx_en) begin
      state           <= ST_IDLE;
      sreg            <= '0;
      cnt             <= '0;
      last_fifo       <= 1'b0;
      tx_serial_valid <= 1'b0;
      tx_idle_pattern <= 1'b0;
      tx_active       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state           <= ST_SYNC;
          sreg            <= SYNC_WORD;
          cnt             <= '0;
          prbs            <= 7'h7F;
          tx_serial_valid <= 1'b1;
          tx_idle_pattern <= 1'b0;
          tx_active       <= 1'b1;
        end
        ST_SYNC, ST_DATA: begin
          if (load) begin
            state           <= ST_DATA;
            sreg            <= {4'b0000, nib};
            cnt             <= '0;
            tx_idle_pattern <= nib_idle;
            last_fifo       <= pop;
            if (tx_prbs_en) prbs <= prbs_nxt;
          end else begin
            sreg <= sreg >> 1;
            cnt  <= cnt + 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_ref_24m or negedge rst_n) begin
    if (!rst_n) begin
      tx_overflow  <= 1'b0;
      tx_underflow <= 1'b0;
    end else begin
      if (drop)         tx_overflow <= 1'b1;
      else if (err_clr) tx_overflow <= 1'b0;
      if (unf_set)      tx_underflow <= 1'b1;
      else if (err_clr) tx_underflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_serdesphy_tx_framer.sv
// Bench for serdesphy_tx_framer: directed scenarios plus random traffic against a stream-level model.
module tb_serdesphy_tx_framer;
  localparam int         DEPTH    = 8;
  localparam logic [3:0] IDLE_NIB = 4'h5;

  logic clk_ref_24m = 1'b0;
  logic rst_n, tx_en, tx_fifo_en, tx_prbs_en, tx_idle, err_clr, tx_valid;
  logic [3:0] tx_data;
  logic tx_serial_data, tx_serial_valid, tx_idle_pattern, tx_fifo_full, tx_fifo_empty;
  logic tx_overflow, tx_underflow, tx_active;
  logic [7:0] dut_vec;

  int errors = 0;
  int checks = 0;

  // Model: m_k is the index of the bit on the line since enable (-1 when idle).
  int          m_k, m_pidx;
  logic [3:0]  m_cur;
  logic        m_cur_idle, m_last_fifo, m_ovf, m_unf;
  logic [3:0]  m_q[$];
  logic [126:0] prbs_seq;

  serdesphy_tx_framer #(.FIFO_DEPTH(DEPTH), .SYNC_WORD(8'hA5), .IDLE_NIBBLE(4'h5)) dut (
    .clk_ref_24m(clk_ref_24m), .rst_n(rst_n), .tx_en(tx_en), .tx_fifo_en(tx_fifo_en),
    .tx_prbs_en(tx_prbs_en), .tx_idle(tx_idle), .err_clr(err_clr), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_serial_data(tx_serial_data), .tx_serial_valid(tx_serial_valid),
    .tx_idle_pattern(tx_idle_pattern), .tx_fifo_full(tx_fifo_full), .tx_fifo_empty(tx_fifo_empty),
    .tx_overflow(tx_overflow), .tx_underflow(tx_underflow), .tx_active(tx_active)
  );

  always #5 clk_ref_24m = ~clk_ref_24m;

  assign dut_vec = {tx_serial_valid, tx_serial_data, tx_idle_pattern, tx_active,
                    tx_fifo_full, tx_fifo_empty, tx_overflow, tx_underflow};

  task automatic build_prbs();
    logic [6:0] r;
    logic b;
    r = 7'h7F;
    for (int i = 0; i < 127; i++) begin
      b = r[6] ^ r[5];
      prbs_seq[i] = b;
      r = {r[5:0], b};
    end
  endtask

  task automatic model_reset();
    m_k = -1; m_pidx = 0; m_cur = '0; m_cur_idle = 1'b0;
    m_last_fifo = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    m_q.delete();
  endtask

  task automatic model_edge();
    logic ovf_set, unf_set;
    logic [3:0] n;
    int p, idx;
    ovf_set = 1'b0; unf_set = 1'b0; n = IDLE_NIB;
    if (!tx_en) begin
      m_k = -1; m_last_fifo = 1'b0; m_cur_idle = 1'b0;
    end else if (m_k < 0) begin
      m_k = 0; m_pidx = 0;
    end else begin
      p = m_k - 8;
      if (m_k == 7 || (m_k >= 8 && p[1:0] == 2'd3)) begin
        if (tx_prbs_en) begin
          for (int j = 0; j < 4; j++) begin
            idx = (m_pidx + j) % 127;
            n[j[1:0]] = prbs_seq[idx[6:0]];
          end
          m_pidx = m_pidx + 4; m_cur_idle = 1'b0; m_last_fifo = 1'b0;
        end else if (tx_idle) begin
          m_cur_idle = 1'b1; m_last_fifo = 1'b0;
        end else if (m_q.size() > 0) begin
          n = m_q.pop_front(); m_cur_idle = 1'b0; m_last_fifo = 1'b1;
        end else begin
          m_cur_idle = 1'b1; unf_set = m_last_fifo; m_last_fifo = 1'b0;
        end
        m_cur = n;
      end
      m_k++;
    end
    if (tx_fifo_en && tx_valid) begin
      if (m_q.size() < DEPTH) m_q.push_back(tx_data);
      else ovf_set = 1'b1;
    end
    if (ovf_set) m_ovf = 1'b1; else if (err_clr) m_ovf = 1'b0;
    if (unf_set) m_unf = 1'b1; else if (err_clr) m_unf = 1'b0;
  endtask

  function automatic logic [7:0] exp_vec();
    logic [7:0] sw;
    logic v, d, ip;
    int p;
    sw = 8'hA5; v = (m_k >= 0); d = 1'b0; ip = 1'b0;
    if (m_k >= 0 && m_k < 8) d = sw[m_k[2:0]];
    else if (m_k >= 8) begin
      p = m_k - 8; d = m_cur[p[1:0]]; ip = m_cur_idle;
    end
    return {v, d, ip, v, (m_q.size() == DEPTH), (m_q.size() == 0), m_ovf, m_unf};
  endfunction

  task automatic cycle();
    model_edge();
    @(posedge clk_ref_24m); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tx_en = 1'b0; tx_fifo_en = 1'b0; tx_prbs_en = 1'b0; tx_idle = 1'b0;
    err_clr = 1'b0; tx_valid = 1'b0; tx_data = '0;
    model_reset();
    repeat (2) @(posedge clk_ref_24m);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec !== 8'h04) begin errors++; $display("FAIL reset_values got=%b exp=%b", dut_vec, 8'h04); end
    tx_en = 1'b1; tx_fifo_en = 1'b1; tx_valid = 1'b1; tx_data = 4'hA;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL pre_reset cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec()); end
    end
    tx_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 8'h04) begin errors++; $display("FAIL async_reset got=%b exp=%b", dut_vec, 8'h04); end
    model_reset();
    @(posedge clk_ref_24m); #1;
    checks++;
    if (dut_vec !== 8'h04) begin errors++; $display("FAIL reset_hold got=%b exp=%b", dut_vec, 8'h04); end
    tx_en = 1'b0; tx_fifo_en = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_sync_idle();
    logic [7:0] acc;
    do_reset();
    acc = '0; tx_en = 1'b1;
    for (int i = 0; i < 28; i++) begin
      cycle();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL sync_idle cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec()); end
      if (i < 8) acc[i[2:0]] = tx_serial_data;
    end
    checks++;
    if (acc !== 8'hA5) begin errors++; $display("FAIL sync_word got=%h exp=a5", acc); end
  endtask

  task automatic test_data_underflow();
    logic [7:0] acc;
    int p;
    do_reset();
    acc = '0; tx_en = 1'b1; tx_fifo_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tx_valid = (i == 1 || i == 2);
      tx_data  = (i == 1) ? 4'h3 : 4'hC;
      cycle();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL data_underflow cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec()); end
      if (m_k >= 8 && m_k < 16) begin p = m_k - 8; acc[p[2:0]] = tx_serial_data; end
    end
    checks++;
    if (acc !== 8'hC3) begin errors++; $display("FAIL data_bits got=%b exp=%b", acc, 8'hC3); end
    checks++;
    if (tx_underflow !== 1'b1) begin errors++; $display("FAIL underflow_set got=%b exp=1", tx_underflow); end
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    checks++;
    if (tx_underflow !== 1'b0) begin errors++; $display("FAIL underflow_clr got=%b exp=0", tx_underflow); end
  endtask

  task automatic test_overflow_drain();
    logic [3:0] pushed[$];
    logic [3:0] got[$];
    logic [3:0] acc;
    int p;
    do_reset();
    tx_fifo_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tx_valid = 1'b1; tx_data = 4'($urandom_range(0, 15));
      if (i < 8) pushed.push_back(tx_data);
      cycle();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL fill cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec()); end
    end
    tx_valid = 1'b0;
    checks++;
    if (tx_fifo_full !== 1'b1 || tx_overflow !== 1'b1)
      begin errors++; $display("FAIL overflow full=%b ovf=%b exp=1,1", tx_fifo_full, tx_overflow); end
    tx_en = 1'b1; acc = '0;
    for (int i = 0; i < 56; i++) begin
      cycle();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL drain cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec()); end
      if (m_k >= 8) begin
        p = m_k - 8; acc[p[1:0]] = tx_serial_data;
        if (p[1:0] == 2'd3) got.push_back(acc);
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got.size() <= i || got[i] !== pushed[i])
        begin errors++; $display("FAIL drain_order idx=%0d got=%h exp=%h", i, (got.size() > i) ? got[i] : 4'hx, pushed[i]); end
    end
  endtask

  task automatic test_prbs();
    logic [7:0] acc;
    int p;
    do_reset();
    acc = '0; tx_prbs_en = 1'b1; tx_en = 1'b1;
    for (int i = 0; i < 268; i++) begin
      cycle();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL prbs cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec()); end
      if (m_k >= 8 && m_k < 16) begin p = m_k - 8; acc[p[2:0]] = tx_serial_data; end
    end
    checks++;
    if (acc !== 8'h40) begin errors++; $display("FAIL prbs_first8 got=%b exp=%b", acc, 8'h40); end
  endtask

  task automatic test_abort();
    logic [7:0] acc;
    do_reset();
    tx_en = 1'b1; tx_fifo_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1'b1; tx_data = 4'($urandom_range(0, 15));
      cycle();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL abort_fill cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec()); end
    end
    tx_valid = 1'b0;
    for (int n = 0; n < 20 && m_k != 9; n++) cycle();
    checks++;
    if (m_k != 9 || dut_vec !== exp_vec()) begin errors++; $display("FAIL abort_reach k=%0d got=%b exp=%b", m_k, dut_vec, exp_vec()); end
    tx_en = 1'b0;
    cycle();
    checks++;
    if (tx_serial_valid !== 1'b0 || dut_vec !== exp_vec())
      begin errors++; $display("FAIL abort_drop got=%b exp=%b", dut_vec, exp_vec()); end
    repeat (3) cycle();
    tx_en = 1'b1; acc = '0;
    for (int i = 0; i < 28; i++) begin
      cycle();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL abort_restart cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec()); end
      if (i < 8) acc[i[2:0]] = tx_serial_data;
    end
    checks++;
    if (acc !== 8'hA5) begin errors++; $display("FAIL abort_resync got=%h exp=a5", acc); end
  endtask

  task automatic test_full_push_pop();
    logic [3:0] pushed[$];
    logic [3:0] got[$];
    logic [3:0] acc, newn;
    int p;
    do_reset();
    tx_fifo_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tx_valid = 1'b1; tx_data = 4'($urandom_range(0, 15));
      pushed.push_back(tx_data);
      cycle();
    end
    tx_valid = 1'b0;
    newn = 4'($urandom_range(0, 15));
    pushed.push_back(newn);
    tx_en = 1'b1; acc = '0;
    for (int i = 0; i < 56; i++) begin
      tx_valid = (m_k == 7);
      tx_data  = newn;
      cycle();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL push_pop cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec()); end
      if (m_k == 8) begin
        checks++;
        if (tx_fifo_full !== 1'b1 || tx_overflow !== 1'b0)
          begin errors++; $display("FAIL push_pop_full full=%b ovf=%b exp=1,0", tx_fifo_full, tx_overflow); end
      end
      if (m_k >= 8) begin
        p = m_k - 8; acc[p[1:0]] = tx_serial_data;
        if (p[1:0] == 2'd3) got.push_back(acc);
      end
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got.size() <= i || got[i] !== pushed[i])
        begin errors++; $display("FAIL push_pop_order idx=%0d got=%h exp=%h", i, (got.size() > i) ? got[i] : 4'hx, pushed[i]); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tx_en      = ($urandom_range(0, 149) != 0);
      tx_fifo_en = ($urandom_range(0, 7) != 0);
      tx_valid   = ($urandom_range(0, 2) == 0);
      tx_data    = 4'($urandom_range(0, 15));
      err_clr    = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 199) == 0) tx_prbs_en = ~tx_prbs_en;
      if ($urandom_range(0, 99) == 0)  tx_idle    = ~tx_idle;
      cycle();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec()); end
    end
  endtask

  initial begin
    build_prbs();
    test_reset();
    test_sync_idle();
    test_data_underflow();
    test_overflow_drain();
    test_prbs();
    test_abort();
    test_full_push_pop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
